muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/div_core.sv | 78 +++++++
 rtl/muldiv_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM states and divider constants for the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = XLEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // DIV and REM are the signed divide ops
    function automatic logic op_is_signed_div(input logic [2:0] op);
        return op[2] & ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Iterative restoring divider on unsigned magnitudes, one
//               quotient bit per cycle, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module div_core
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_ITER,
    localparam int CNT_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] quo_o,
    output logic [DATA_WIDTH-1:0] rem_o
);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;

    logic [DATA_WIDTH:0]   w_shifted;
    logic [DATA_WIDTH:0]   w_trial;

    // Quotient register doubles as the dividend shift register
    assign w_shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, dvs_q};

    always_comb begin
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (start_i) begin
            cnt_d = CNT_W'(DATA_WIDTH);
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (!w_trial[DATA_WIDTH]) begin
                rem_d = w_trial[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = w_shifted[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    // High during the final iteration; results are valid the following cycle
    assign done_o = (cnt_q == CNT_W'(1));
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multiply/divide unit controller: pipelined multiply, iterative
//               divide with sign fix-up and divide-by-zero/overflow fast path.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH  = XLEN,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [2:0]            WAIT_LAST = 3'(MUL_LATENCY - 1);

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [2:0]            wait_q, wait_d;

    // ---------------- multiply datapath ----------------
    logic                    w_mul_a_sx;
    logic                    w_mul_b_sx;
    logic [2*DATA_WIDTH-1:0] w_mul_full;
    logic [DATA_WIDTH-1:0]   w_mul_stage [MUL_LATENCY];

    assign w_mul_a_sx = (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10) & a_q[DATA_WIDTH-1];
    assign w_mul_b_sx = (op_q[1:0] == 2'b01) & b_q[DATA_WIDTH-1];
    assign w_mul_full = $signed({w_mul_a_sx, a_q}) * $signed({w_mul_b_sx, b_q});
    assign w_mul_stage[0] = (op_q[1:0] == 2'b00) ? w_mul_full[DATA_WIDTH-1:0]
                                                 : w_mul_full[2*DATA_WIDTH-1:DATA_WIDTH];

    // Operand registers count as the first pipeline stage
    for (genvar i = 1; i < MUL_LATENCY; i++) begin : g_mul_stage
        logic [DATA_WIDTH-1:0] stage_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage_q <= '0;
            else        stage_q <= w_mul_stage[i-1];
        end
        assign w_mul_stage[i] = stage_q;
    end

    // ---------------- divide datapath ----------------
    logic                  w_accept;
    logic                  w_div_signed;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH-1:0] w_fast_res;
    logic                  w_div_start;
    logic                  w_div_done;
    logic [DATA_WIDTH-1:0] w_div_quo;
    logic [DATA_WIDTH-1:0] w_div_rem;
    logic                  w_fix_a_neg;
    logic                  w_fix_b_neg;
    logic [DATA_WIDTH-1:0] w_fix_res;

    assign w_accept     = (state_q == ST_IDLE) && start_i;
    assign w_div_signed = op_is_signed_div(op_i);
    assign w_div_zero   = (b_i == '0);
    assign w_div_ovf    = w_div_signed && (a_i == MIN_NEG) && (b_i == '1);
    assign w_a_mag      = (w_div_signed && a_i[DATA_WIDTH-1]) ? -a_i : a_i;
    assign w_b_mag      = (w_div_signed && b_i[DATA_WIDTH-1]) ? -b_i : b_i;
    assign w_fast_res   = w_div_zero ? (op_i[1] ? a_i : '1)
                                     : (op_i[1] ? '0  : MIN_NEG);
    assign w_div_start  = w_accept && op_is_div(op_i) && !w_div_zero && !w_div_ovf;

    div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (w_div_start),
        .dividend_i (w_a_mag),
        .divisor_i  (w_b_mag),
        .done_o     (w_div_done),
        .quo_o      (w_div_quo),
        .rem_o      (w_div_rem)
    );

    // Remainder sign follows the dividend; quotient sign is the XOR of both
    assign w_fix_a_neg = op_is_signed_div(op_q) & a_q[DATA_WIDTH-1];
    assign w_fix_b_neg = op_is_signed_div(op_q) & b_q[DATA_WIDTH-1];
    assign w_fix_res   = op_q[1] ? (w_fix_a_neg ? -w_div_rem : w_div_rem)
                                 : ((w_fix_a_neg ^ w_fix_b_neg) ? -w_div_quo : w_div_quo);

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    op_d = op_i;
                    a_d  = a_i;
                    b_d  = b_i;
                    if (!op_is_div(op_i)) begin
                        state_d = ST_MUL_WAIT;
                        wait_d  = '0;
                    end else if (w_div_zero || w_div_ovf) begin
                        state_d = ST_DONE;
                        res_d   = w_fast_res;
                    end else begin
                        state_d = ST_DIV_RUN;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                    res_d   = w_mul_stage[MUL_LATENCY-1];
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_DIV_RUN: begin
                if (w_div_done) state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                state_d = ST_DONE;
                res_d   = w_fix_res;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            wait_q  <= wait_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign res_o  = res_q;

endmodule
`default_nettype wire
